// File: rtl/uart_frame_receiver_pkg.sv
// uart_frame_receiver_pkg: shared baud default and receiver state encodings
package uart_frame_receiver_pkg;
  localparam int UART_CLKS_PER_BIT = 434;
  typedef enum logic [2:0] {
    URX_IDLE  = 3'd0,
    URX_START = 3'd1,
    URX_DATA  = 3'd2,
    URX_STOP  = 3'd3,
    URX_BREAK = 3'd4
  } urx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input with selectable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver: 8N1 UART receiver with glitch rejection, framing error and break hold-off
module uart_frame_receiver
  import uart_frame_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  urx_state_e    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d, byte_d;
  logic          valid_d, err_d, rx_s;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= URX_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_byte      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      shift       <= shift_d;
      o_byte      <= byte_d;
      o_valid     <= valid_d;
      o_frame_err <= err_d;
    end
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    shift_d = shift;
    byte_d  = o_byte;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state)
      URX_IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? URX_IDLE : URX_START;
      end
      URX_START:
        if (cnt == HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? URX_IDLE : URX_DATA;
        end
      URX_DATA:
        if (cnt == BIT_END) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          idx_d        = idx + 1'b1;
          state_d      = (idx == 3'd7) ? URX_STOP : URX_DATA;
        end
      URX_STOP:
        if (cnt == BIT_END) begin
          cnt_d   = '0;
          valid_d = rx_s;
          err_d   = !rx_s;
          byte_d  = rx_s ? shift : o_byte;
          state_d = rx_s ? URX_IDLE : URX_BREAK;
        end
      URX_BREAK: begin
        cnt_d   = '0;
        state_d = rx_s ? URX_IDLE : URX_BREAK;
      end
      default: state_d = URX_IDLE;
    endcase
  end
  assign o_busy = (state != URX_IDLE);
endmodule
